// File: rtl/render_snake_body.sv
// Multi-segment snake: grid body state, tick movement, growth, collisions, colour layer.
// Optional build macro SNAKE_WRAP_EN: edges wrap instead of killing the snake.
module render_snake_body #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int SEG_LOG2 = 4,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [63:0]   i_s_axis_tdata,
    input  logic          i_s_axis_tvalid,
    input  logic          i_s_axis_tlast,
    output logic          o_s_axis_tready,
    input  logic          i_move_tick,
    input  logic [9:0]    i_pixel_x,
    input  logic [9:0]    i_pixel_y,
    input  logic          i_video_on,
    output logic [3:0]    o_vga_r,
    output logic [3:0]    o_vga_g,
    output logic [3:0]    o_vga_b,
    output logic [5:0]    o_head_x,
    output logic [4:0]    o_head_y,
    output logic [LW-1:0] o_length,
    output logic [1:0]    o_state,
    output logic          o_collision
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    localparam logic [2:0] D_UP    = 3'd1;
    localparam logic [2:0] D_DOWN  = 3'd2;
    localparam logic [2:0] D_LEFT  = 3'd3;
    localparam logic [2:0] D_RIGHT = 3'd4;

    localparam logic [5:0]    X0   = 6'(GRID_W / 2);
    localparam logic [4:0]    Y0   = 5'(GRID_H / 2);
    localparam logic [5:0]    XMAX = 6'(GRID_W - 1);
    localparam logic [4:0]    YMAX = 5'(GRID_H - 1);
    localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);
    localparam logic [LW-1:0] LINI = LW'(INIT_LEN);

    function automatic logic [2:0] f_opp(input logic [2:0] d);
        case (d)
            D_UP:    f_opp = D_DOWN;
            D_DOWN:  f_opp = D_UP;
            D_LEFT:  f_opp = D_RIGHT;
            D_RIGHT: f_opp = D_LEFT;
            default: f_opp = 3'd0;
        endcase
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [5:0]    r_seg_x [MAX_LEN];
    logic [4:0]    r_seg_y [MAX_LEN];
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_pend;
    logic [2:0]    r_dir;
    logic [2:0]    r_dir_pend;
    logic          r_coll;
    logic [3:0]    r_r, r_g, r_b;

    logic          w_cmd, w_dir_ok, w_grow, w_restart, w_tick;
    logic [2:0]    w_cmd_dir;
    logic [5:0]    w_nx;
    logic [4:0]    w_ny;
    logic          w_wall, w_self, w_hit, w_growing, w_dec;
    logic [LW:0]   w_pend_sum;
    logic [LW-1:0] w_pend_nxt;
    logic [9:0]    w_cx, w_cy;
    logic          w_head_px, w_body_px;
    logic [3:0]    w_r, w_g, w_b;
    logic          w_unused;

    assign o_s_axis_tready = 1'b1;
    assign w_unused  = ^i_s_axis_tdata[63:24];

    assign w_cmd     = i_s_axis_tvalid && i_s_axis_tlast
                       && (i_s_axis_tdata[7:0] == 8'h01);
    assign w_cmd_dir = i_s_axis_tdata[10:8];
    assign w_dir_ok  = w_cmd && (i_s_axis_tdata[15:8] >= 8'd1)
                       && (i_s_axis_tdata[15:8] <= 8'd4)
                       && (w_cmd_dir != f_opp(r_dir))
                       && (r_state != S_DEAD);
    assign w_grow    = w_cmd && (i_s_axis_tdata[23:16] == 8'd1);
    assign w_restart = w_cmd && (i_s_axis_tdata[23:16] == 8'd2)
                       && (r_state == S_DEAD);
    assign w_tick    = i_move_tick && (r_state == S_RUN);
    assign w_growing = (r_pend != '0) && (r_len < LMAX);

    // Candidate head cell for the pending direction, with edge handling
    always_comb begin
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        case (r_dir_pend)
            D_UP: begin
                if (r_seg_y[0] == 5'd0) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = YMAX;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_ny = r_seg_y[0] - 5'd1;
                end
            end
            D_DOWN: begin
                if (r_seg_y[0] == YMAX) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = 5'd0;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_ny = r_seg_y[0] + 5'd1;
                end
            end
            D_LEFT: begin
                if (r_seg_x[0] == 6'd0) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = XMAX;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_nx = r_seg_x[0] - 6'd1;
                end
            end
            D_RIGHT: begin
                if (r_seg_x[0] == XMAX) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = 6'd0;
`else
                    w_wall = 1'b1;
`endif
                end else begin
                    w_nx = r_seg_x[0] + 6'd1;
                end
            end
            default: ;
        endcase
    end

    // Self hit: the tail cell only counts when it stays put this step
    always_comb begin
        w_self = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((LW'(i) + LW'(1)) < r_len || (w_growing && LW'(i) < r_len))
                && r_seg_x[i] == w_nx && r_seg_y[i] == w_ny)
                w_self = 1'b1;
        end
    end

    assign w_hit = w_tick && (w_wall || w_self);
    assign w_dec = w_tick && !w_hit && w_growing;

    // Saturating grow credit: add this cycle's request, spend one on a growing step
    always_comb begin
        w_pend_sum = {1'b0, r_pend} + (LW+1)'(w_grow) - (LW+1)'(w_dec);
        w_pend_nxt = (w_pend_sum > (LW+1)'(MAX_LEN)) ? LMAX : w_pend_sum[LW-1:0];
    end

    // Game state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Game state transitions
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_dir_ok)  w_state_nxt = S_RUN;
            S_RUN:   if (w_hit)     w_state_nxt = S_DEAD;
            S_DEAD:  if (w_restart) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Body, length, grow credit and direction bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= X0 - 6'(i);
                r_seg_y[i] <= Y0;
            end
            r_len      <= LINI;
            r_pend     <= '0;
            r_dir      <= D_RIGHT;
            r_dir_pend <= D_RIGHT;
            r_coll     <= 1'b0;
        end else if (w_restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= X0 - 6'(i);
                r_seg_y[i] <= Y0;
            end
            r_len      <= LINI;
            r_pend     <= '0;
            r_dir      <= D_RIGHT;
            r_dir_pend <= D_RIGHT;
            r_coll     <= 1'b0;
        end else begin
            r_coll <= w_hit;
            r_pend <= w_pend_nxt;
            if (w_dir_ok) r_dir_pend <= w_cmd_dir;
            if (w_tick && !w_hit) begin
                r_dir      <= r_dir_pend;
                r_seg_x[0] <= w_nx;
                r_seg_y[0] <= w_ny;
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                if (w_growing) r_len <= r_len + LW'(1);
            end
        end
    end

    assign w_cx = i_pixel_x >> SEG_LOG2;
    assign w_cy = i_pixel_y >> SEG_LOG2;

    // Parallel match of the pixel cell against every live segment
    always_comb begin
        w_head_px = (w_cx == 10'(r_seg_x[0])) && (w_cy == 10'(r_seg_y[0]));
        w_body_px = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (LW'(i) < r_len && w_cx == 10'(r_seg_x[i])
                && w_cy == 10'(r_seg_y[i]))
                w_body_px = 1'b1;
        end
        w_r = 4'h0;
        w_g = 4'h0;
        w_b = 4'h0;
        if (i_video_on) begin
            if (w_head_px) begin
                w_r = 4'hF;
                w_g = 4'hF;
            end else if (w_body_px) begin
                if (r_state == S_DEAD) w_r = 4'hF;
                else                   w_g = 4'hF;
            end
        end
    end

    // Registered colour output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_r <= 4'h0;
            r_g <= 4'h0;
            r_b <= 4'h0;
        end else begin
            r_r <= w_r;
            r_g <= w_g;
            r_b <= w_b;
        end
    end

    assign o_vga_r     = r_r;
    assign o_vga_g     = r_g;
    assign o_vga_b     = r_b;
    assign o_head_x    = r_seg_x[0];
    assign o_head_y    = r_seg_y[0];
    assign o_length    = r_len;
    assign o_state     = r_state;
    assign o_collision = r_coll;

endmodule
